// File: rtl/ann_pkg.sv
// Shared definitions for the neural-network layer stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ann_pkg;

  // Default geometry of one neuron stage.
  localparam int ANN_DATA_W   = 16;
  localparam int ANN_FRAC_W   = 8;
  localparam int ANN_ADDR_W   = 5;
  localparam int ANN_N_INPUTS = 28;
  localparam int ANN_ACC_W    = 40;

  // Sequencer state encoding shared by the MAC stages.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } mac_state_e;

  // Q8.8 reference constants.
  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

endpackage

// File: rtl/fxp_sat_relu.sv
// Rescales a wide fixed-point accumulator to DATA_W, saturates, then optional ReLU.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fxp_sat_relu #(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              relu_en,
  output logic [DATA_W-1:0] y_out,
  output logic              sat_out
);

  // Largest and smallest DATA_W signed values, sign-extended to ACC_W.
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  // Arithmetic shift drops the extra fraction bits with floor rounding.
  assign shifted = $signed(acc_in) >>> FRAC_W;

  // Clip to the DATA_W range first; ReLU then zeroes negatives without touching the clip flag.
  always_comb begin
    y_out   = shifted[DATA_W-1:0];
    sat_out = 1'b0;
    if (shifted > MAX_V) begin
      y_out   = MAX_V[DATA_W-1:0];
      sat_out = 1'b1;
    end else if (shifted < MIN_V) begin
      y_out   = MIN_V[DATA_W-1:0];
      sat_out = 1'b1;
    end
    if (relu_en && y_out[DATA_W-1]) begin
      y_out = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single-neuron dot product: sweeps weight/input BRAMs, accumulates, adds bias, saturates, ReLU.
// Latency: y_valid pulses N_INPUTS+1 clocks after start is accepted; one neuron per N_INPUTS+2.
// Backpressure: none; start is ignored while busy and the result is a one-cycle valid pulse.
module neuron_mac_unit
  import ann_pkg::*;
#(
  parameter int N_INPUTS = ANN_N_INPUTS,
  parameter int ADDR_W   = ANN_ADDR_W,
  parameter int DATA_W   = ANN_DATA_W,
  parameter int FRAC_W   = ANN_FRAC_W,
  parameter int ACC_W    = ANN_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              relu_en,
  input  logic [DATA_W-1:0] bias,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  output logic              w_we,
  input  logic [DATA_W-1:0] w_do,
  output logic [ADDR_W-1:0] x_addr,
  output logic              x_en,
  input  logic [DATA_W-1:0] x_do,
  output logic              busy,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              sat
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  mac_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] bias_q, bias_d;
  logic              relu_q, relu_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic              sat_q, sat_d;

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           bias_ext;
  logic [ACC_W-1:0]           biased_sum;
  logic [DATA_W-1:0]          sr_y;
  logic                       sr_sat;

  // Full-precision product of the BRAM words that arrived on the preceding negedge.
  assign prod     = $signed(w_do) * $signed(x_do);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Bias is aligned to the product's 2*FRAC_W fraction before the final rescale.
  assign bias_ext   = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
  assign biased_sum = acc_q + (bias_ext << FRAC_W);

  fxp_sat_relu #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_sat_relu (
    .acc_in  (biased_sum),
    .relu_en (relu_q),
    .y_out   (sr_y),
    .sat_out (sr_sat)
  );

  // Sequencer: accept start, sweep the address range, then register the rescaled result.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    en_d      = en_q;
    busy_d    = busy_q;
    acc_d     = acc_q;
    bias_d    = bias_q;
    relu_d    = relu_q;
    y_d       = y_q;
    sat_d     = sat_q;
    y_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bias_d  = bias;
          relu_d  = relu_en;
          acc_d   = '0;
          addr_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + prod_ext;
        if (addr_q == LAST_ADDR) begin
          en_d    = 1'b0;
          addr_d  = '0;
          state_d = ST_FINISH;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_FINISH: begin
        y_d       = sr_y;
        sat_d     = sr_sat;
        y_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any sweep and clears the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      acc_q     <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      acc_q     <= acc_d;
      bias_q    <= bias_d;
      relu_q    <= relu_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sat_q     <= sat_d;
    end
  end

  // Both BRAMs share one address and enable; this block never writes.
  assign w_addr  = addr_q;
  assign x_addr  = addr_q;
  assign w_en    = en_q;
  assign x_en    = en_q;
  assign w_we    = 1'b0;
  assign busy    = busy_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Bench for neuron_mac_unit: negedge-read BRAM models, directed scenarios, result scoreboard.
// Latency: each evaluation is expected to raise y_valid 29 clocks after start is accepted.
// Backpressure: none in the DUT; start is held high in one scenario to exercise the ignore rule.
module tb_neuron_mac_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        relu_en;
  logic [15:0] bias;
  logic [4:0]  w_addr;
  logic        w_en;
  logic        w_we;
  logic [15:0] w_do;
  logic [4:0]  x_addr;
  logic        x_en;
  logic [15:0] x_do;
  logic        busy;
  logic [15:0] y;
  logic        y_valid;
  logic        sat;

  typedef struct packed {
    logic [15:0] y;
    logic        sat;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails  = 0;
  logic [15:0] wmem [0:31];
  logic [15:0] xmem [0:31];

  neuron_mac_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .relu_en (relu_en),
    .bias    (bias),
    .w_addr  (w_addr),
    .w_en    (w_en),
    .w_we    (w_we),
    .w_do    (w_do),
    .x_addr  (x_addr),
    .x_en    (x_en),
    .x_do    (x_do),
    .busy    (busy),
    .y       (y),
    .y_valid (y_valid),
    .sat     (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: registered read on the falling edge when enabled.
  always @(negedge clk) begin
    if (w_en === 1'b1) w_do <= wmem[w_addr];
    if (x_en === 1'b1) x_do <= xmem[x_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every y_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (y_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_y_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("y", {16'd0, y}, {16'd0, mon_e.y});
        chk("sat", {31'd0, sat}, {31'd0, mon_e.sat});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish after %0d checks, expected finish", checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic load_const(input logic [15:0] wv, input logic [15:0] xv);
    for (int i = 0; i < 32; i++) begin
      wmem[i] = wv;
      xmem[i] = xv;
    end
  endtask

  // One evaluation: pulse start, track address/enable per cycle, check timing and busy.
  task automatic run_eval(input string tag, input logic [15:0] b, input logic r,
                          input logic [15:0] ey, input logic es);
    int   lat;
    int   en_cnt;
    int   addr_err;
    logic busy0;
    logic busy_end;
    exp_t e;
    e.y   = ey;
    e.sat = es;
    sb_q.push_back(e);
    @(negedge clk);
    start   = 1'b1;
    bias    = b;
    relu_en = r;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = -1;
    en_cnt   = 0;
    addr_err = 0;
    busy0    = busy;
    busy_end = 1'bx;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (w_en === 1'b1) begin
        en_cnt++;
        if (int'(w_addr) != c) addr_err++;
      end
      if (x_en !== w_en || x_addr !== w_addr) addr_err++;
      if (y_valid === 1'b1) begin
        lat      = c;
        busy_end = busy;
        break;
      end
    end
    chk({tag, ".latency"}, lat, 32'd29);
    chk({tag, ".en_cycles"}, en_cnt, 32'd28);
    chk({tag, ".addr_seq_errors"}, addr_err, 32'd0);
    chk({tag, ".busy_start"}, {31'd0, busy0}, 32'd1);
    chk({tag, ".busy_done"}, {31'd0, busy_end}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".y_valid_one_cycle"}, {31'd0, y_valid}, 32'd0);
    chk({tag, ".y_held"}, {16'd0, y}, {16'd0, ey});
  endtask

  initial begin
    int vcnt;
    int vt [3];
    logic busy_mid;

    rst_n   = 1'b0;
    start   = 1'b0;
    relu_en = 1'b0;
    bias    = 16'h0000;
    load_const(16'h0000, 16'h0000);

    // Reset values.
    #12;
    chk("rst.y", {16'd0, y}, 32'd0);
    chk("rst.y_valid", {31'd0, y_valid}, 32'd0);
    chk("rst.sat", {31'd0, sat}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.w_en", {31'd0, w_en}, 32'd0);
    chk("rst.x_en", {31'd0, x_en}, 32'd0);
    chk("rst.w_addr", {27'd0, w_addr}, 32'd0);
    chk("rst.w_we", {31'd0, w_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 28 x (1.0 * 1.0) = 28.0
    load_const(16'h0100, 16'h0100);
    run_eval("s1", 16'h0000, 1'b0, 16'h1C00, 1'b0);

    // 28 x (-1.0) + 2.0 = -26.0, and the same with ReLU.
    load_const(16'hFF00, 16'h0100);
    run_eval("s2", 16'h0200, 1'b0, 16'hE600, 1'b0);
    run_eval("s2_relu", 16'h0200, 1'b1, 16'h0000, 1'b0);

    // Positive and negative overflow clip to the range limits.
    load_const(16'h7FFF, 16'h7FFF);
    run_eval("s3_pos", 16'h0000, 1'b0, 16'h7FFF, 1'b1);
    load_const(16'h8000, 16'h7FFF);
    run_eval("s3_neg", 16'h0000, 1'b0, 16'h8000, 1'b1);

    // Reset ten cycles into a sweep while the previous result (0x8000, sat) is held.
    load_const(16'h0100, 16'h0100);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5.w_en", {31'd0, w_en}, 32'd0);
    chk("s5.x_en", {31'd0, x_en}, 32'd0);
    chk("s5.busy", {31'd0, busy}, 32'd0);
    chk("s5.y", {16'd0, y}, 32'd0);
    chk("s5.sat", {31'd0, sat}, 32'd0);
    chk("s5.y_valid", {31'd0, y_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_eval("s5_after", 16'h0000, 1'b0, 16'h1C00, 1'b0);

    // W[i] = i.0, X = 0.5, bias = 1/256: 189.0 + 1/256 exceeds Q8.8, so it clips.
    for (int i = 0; i < 32; i++) begin
      wmem[i] = 16'(i * 256);
      xmem[i] = 16'h0080;
    end
    run_eval("s4", 16'h0001, 1'b0, 16'h7FFF, 1'b1);

    // W[i] = i/32, X = 0.5: sum = 378/64 = 5.90625 (0x05E8) plus 1/256.
    for (int i = 0; i < 32; i++) wmem[i] = 16'(i * 8);
    run_eval("s4_small", 16'h0001, 1'b0, 16'h05E9, 1'b0);

    // Sum of 28 x (-1/256 * 1/256) floors to -1/256.
    load_const(16'hFFFF, 16'h0001);
    run_eval("floor", 16'h0000, 1'b0, 16'hFFFF, 1'b0);

    // start held high: accepted at cycles 0, 30, 60; ignored while busy.
    load_const(16'h0100, 16'h0100);
    for (int k = 0; k < 3; k++) sb_q.push_back('{y: 16'h1C00, sat: 1'b0});
    vcnt     = 0;
    busy_mid = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    bias    = 16'h0000;
    relu_en = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk);
      #1;
      if (c == 10) busy_mid = busy;
      if (y_valid === 1'b1) begin
        if (vcnt < 3) vt[vcnt] = c;
        vcnt++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("s6.busy_mid", {31'd0, busy_mid}, 32'd1);
    chk("s6.valid_count", vcnt, 32'd3);
    chk("s6.first_valid", vt[0], 32'd29);
    chk("s6.period1", vt[1] - vt[0], 32'd30);
    chk("s6.period2", vt[2] - vt[1], 32'd30);
    repeat (3) @(posedge clk);
    #1;
    chk("s6.idle_after", {31'd0, busy}, 32'd0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
